// File: rtl/sar_scan_sequencer.sv
// sar_scan_sequencer: periodic multi-channel scan scheduler
// for an 8-bit SAR converter with per-channel averaging.
module sar_scan_sequencer #(
    parameter int NCH         = 4,
    parameter int CHW         = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   ch_mask,
    input  logic [15:0]      period,
    input  logic             clr_err,
    input  logic [7:0]       sar_in,
    input  logic             eoc_in,
    output logic             cnvst,
    output logic [CHW-1:0]   mux_sel,
    output logic [7:0]       res_data,
    output logic [CHW-1:0]   res_ch,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             timeout_err,
    output logic             overrun_err
);

    localparam int AW = 8 + AVG_LOG2;
    localparam int SW = AVG_LOG2 + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [SW-1:0] SMP_LAST    = SW'((1 << AVG_LOG2) - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT_EOC,
        OUTPUT,
        NEXT
    } state_t;

    state_t         state;
    logic [15:0]    tmr;
    logic           tmr_load;
    logic           tick;
    logic [NCH-1:0] scan_mask;
    logic [CHW-1:0] ch;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  sum;
    logic [SW-1:0]  smp;
    logic [7:0]     settle_cnt;
    logic [TW-1:0]  to_cnt;
    logic           first_ok;
    logic [CHW-1:0] first_ch;
    logic           next_ok;
    logic [CHW-1:0] next_ch;

    // First cycle after reset only loads the timer, so no spurious tick.
    assign tick = en & ~tmr_load & (tmr == 16'd0);
    assign sum  = acc + AW'(sar_in);

    // Lowest set bit of the live mask, and next higher bit of the scan mask.
    always_comb begin
        first_ok = 1'b0;
        first_ch = '0;
        next_ok  = 1'b0;
        next_ch  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_ok = 1'b1;
                first_ch = CHW'(i);
            end
            if (scan_mask[i] && (CHW'(i) > ch)) begin
                next_ok = 1'b1;
                next_ch = CHW'(i);
            end
        end
    end

    // Scan period down-counter, held at reload while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr      <= '0;
            tmr_load <= 1'b1;
        end else begin
            tmr_load <= 1'b0;
            if (!en || tmr_load || tmr == 16'd0) begin
                tmr <= period;
            end else begin
                tmr <= tmr - 16'd1;
            end
        end
    end

    // Scan sequencer FSM with registered outputs and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            scan_mask   <= '0;
            ch          <= '0;
            acc         <= '0;
            smp         <= '0;
            settle_cnt  <= '0;
            to_cnt      <= '0;
            cnvst       <= 1'b0;
            mux_sel     <= '0;
            res_data    <= '0;
            res_ch      <= '0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            cnvst <= 1'b0;
            if (clr_err) begin
                timeout_err <= 1'b0;
                overrun_err <= 1'b0;
            end
            if (tick && state != IDLE) begin
                overrun_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick && first_ok) begin
                        scan_mask  <= ch_mask;
                        ch         <= first_ch;
                        mux_sel    <= first_ch;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        cnvst <= 1'b1;
                        state <= START;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                START: begin
                    to_cnt <= '0;
                    state  <= WAIT_EOC;
                end
                WAIT_EOC: begin
                    if (eoc_in) begin
                        acc <= sum;
                        smp <= smp + SW'(1);
                        if (smp == SMP_LAST) begin
                            res_data  <= 8'(sum >> AVG_LOG2);
                            res_ch    <= ch;
                            res_valid <= 1'b1;
                            state     <= OUTPUT;
                        end else begin
                            cnvst <= 1'b1;
                            state <= START;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= NEXT;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= NEXT;
                    end
                end
                NEXT: begin
                    acc <= '0;
                    smp <= '0;
                    if (next_ok) begin
                        ch         <= next_ch;
                        mux_sel    <= next_ch;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// tb_sar_scan_sequencer: randomized scans against a channel-list
// scoreboard, plus timeout, stall, back-to-back and reset cases.
module tb_sar_scan_sequencer;

    localparam int NCH     = 4;
    localparam int SETTLE  = 4;
    localparam int ALOG    = 2;
    localparam int NAVG    = 1 << ALOG;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  ch_mask;
    logic [15:0] period;
    logic        clr_err;
    logic [7:0]  sar_in;
    logic        eoc_in;
    logic        cnvst;
    logic [1:0]  mux_sel;
    logic [7:0]  res_data;
    logic [1:0]  res_ch;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic        timeout_err;
    logic        overrun_err;

    int n_chk;
    int n_pass;
    int served[$];
    int conv_ch[$];
    int obs_ch[$];
    int obs_d[$];
    int fixed_q[$];
    int ncnv;
    int wide;
    int mux_bad;
    int wh_ch;
    int cyc;
    int wh_t0;
    int err_t;
    int late_req;
    int late_ack;
    int rdy_mode;

    sar_scan_sequencer #(
        .NCH(NCH), .CHW(2), .SETTLE_CYC(SETTLE),
        .AVG_LOG2(ALOG), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask),
        .period(period), .clr_err(clr_err), .sar_in(sar_in),
        .eoc_in(eoc_in), .cnvst(cnvst), .mux_sel(mux_sel),
        .res_data(res_data), .res_ch(res_ch), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy),
        .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // SAR converter model, result consumer and protocol monitors.
    initial begin
        int pend, dly, pv, stable, prev_mux, prev_cnv, prev_to;
        pend = 0; dly = 0; pv = 0; stable = 0;
        prev_mux = 0; prev_cnv = 0; prev_to = 0;
        eoc_in = 1'b0;
        sar_in = 8'd0;
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            eoc_in = 1'b0;
            res_ready = (rdy_mode == 1) ||
                        (rdy_mode == 2 && $urandom_range(0, 1) == 1);
            if (res_valid && res_ready) begin
                obs_ch.push_back(int'(res_ch));
                obs_d.push_back(int'(res_data));
            end
            if (int'(mux_sel) == prev_mux) stable++;
            else stable = 0;
            prev_mux = int'(mux_sel);
            if (timeout_err && prev_to == 0) err_t = cyc;
            prev_to = int'(timeout_err);
            if (rst) begin
                pend = 0;
            end else begin
                if (pend != 0) begin
                    if (dly == 0) begin
                        eoc_in = 1'b1;
                        sar_in = 8'(pv);
                        served.push_back(pv);
                        pend = 0;
                    end else begin
                        dly--;
                    end
                end
                if (cnvst) begin
                    ncnv++;
                    if (prev_cnv != 0) wide++;
                    if (stable < SETTLE) mux_bad++;
                    conv_ch.push_back(int'(mux_sel));
                    if (int'(mux_sel) == wh_ch) begin
                        wh_t0 = cyc;
                    end else begin
                        pend = 1;
                        dly = $urandom_range(0, 17);
                        if (fixed_q.size() > 0) pv = fixed_q.pop_front();
                        else pv = $urandom_range(0, 255);
                    end
                end
                if (late_req != late_ack) begin
                    eoc_in = 1'b1;
                    sar_in = 8'hA5;
                    late_ack = late_req;
                end
            end
            prev_cnv = int'(cnvst);
        end
    end

    task automatic flush();
        served.delete();
        conv_ch.delete();
        obs_ch.delete();
        obs_d.delete();
    endtask

    task automatic wait_busy(input logic v, input int budget,
                             input string tag);
        int k;
        k = 0;
        while (busy !== v && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, int'(busy === v), 1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    // Expected: channels of the mask in ascending order; each normal
    // channel uses NAVG served samples and yields their truncated mean,
    // a withheld channel issues one conversion and yields nothing.
    task automatic check_scan(input int mask, input int whc,
                              input string tag);
        int ei, ci, si, s;
        ei = 0; ci = 0; si = 0;
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                if (c == whc) begin
                    chk({tag, "_cch"},
                        ci < conv_ch.size() ? conv_ch[ci] : -1, c);
                    ci++;
                end else begin
                    s = 0;
                    for (int k = 0; k < NAVG; k++) begin
                        s += si < served.size() ? served[si] : 0;
                        si++;
                        chk({tag, "_cch"},
                            ci < conv_ch.size() ? conv_ch[ci] : -1, c);
                        ci++;
                    end
                    chk({tag, "_rch"},
                        ei < obs_ch.size() ? obs_ch[ei] : -1, c);
                    chk({tag, "_rdat"},
                        ei < obs_d.size() ? obs_d[ei] : -1, s / NAVG);
                    ei++;
                end
            end
        end
        chk({tag, "_nres"}, obs_d.size(), ei);
        chk({tag, "_ncnv"}, conv_ch.size(), ci);
    endtask

    task automatic run_scan(input int mask, input int per, input int whc,
                            input string tag);
        flush();
        ch_mask = 4'(mask);
        period = 16'(per);
        en = 1'b1;
        wait_busy(1'b1, 100, {tag, "_start"});
        en = 1'b0;
        wait_busy(1'b0, 2000, {tag, "_end"});
        repeat (3) @(negedge clk);
        check_scan(mask, whc, tag);
    endtask

    initial begin
        int k, bad, bz, rises, pb, n0, d0, c0, lat;
        n_chk = 0; n_pass = 0; ncnv = 0; wide = 0; mux_bad = 0;
        wh_ch = -1; cyc = 0; wh_t0 = 0; err_t = 0;
        late_req = 0; late_ack = 0; rdy_mode = 1;
        rst = 1'b1; en = 1'b0; ch_mask = 4'd0; period = 16'd0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cnvst", int'(cnvst), 0);
        chk("rst_mux", int'(mux_sel), 0);
        chk("rst_data", int'(res_data), 0);
        chk("rst_ch", int'(res_ch), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_to", int'(timeout_err), 0);
        chk("rst_ov", int'(overrun_err), 0);
        rst = 1'b0;
        @(negedge clk);

        run_scan(5, 30, -1, "s0101");
        rdy_mode = 2;
        for (int r = 0; r < 4; r++) begin
            run_scan($urandom_range(1, 15), $urandom_range(1, 40), -1,
                     "rnd");
        end
        chk("to_clean", int'(timeout_err), 0);
        chk("ov_clean", int'(overrun_err), 0);
        chk("cnv_width", wide, 0);
        chk("mux_settle", mux_bad, 0);

        rdy_mode = 1;
        wh_ch = 0;
        run_scan(5, 20, 0, "wh");
        wh_ch = -1;
        chk("to_set", int'(timeout_err), 1);
        lat = err_t - wh_t0;
        chk("to_lat", int'(lat >= TIMEOUT && lat <= TIMEOUT + 2), 1);
        pulse_clr();
        chk("to_clr", int'(timeout_err), 0);

        flush();
        fixed_q = '{10, 11, 12, 14};
        rdy_mode = 0;
        ch_mask = 4'b0010;
        period = 16'd10;
        en = 1'b1;
        k = 0;
        while (res_valid !== 1'b1 && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("stall_wait", int'(res_valid === 1'b1), 1);
        d0 = int'(res_data);
        c0 = int'(res_ch);
        n0 = ncnv;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || int'(res_data) != d0 ||
                int'(res_ch) != c0) bad++;
        end
        chk("stall_stable", bad, 0);
        chk("stall_cnv", ncnv - n0, 0);
        chk("avg_data", d0, 11);
        chk("avg_ch", c0, 1);
        chk("ov_set", int'(overrun_err), 1);
        en = 1'b0;
        rdy_mode = 1;
        wait_busy(1'b0, 200, "stall_end");
        repeat (2) @(negedge clk);
        chk("stall_nres", obs_d.size(), 1);
        chk("avg_ncnv", conv_ch.size(), NAVG);
        chk("avg_width", wide, 0);
        chk("avg_settle", mux_bad, 0);
        pulse_clr();
        chk("ov_clr", int'(overrun_err), 0);

        flush();
        ch_mask = 4'd0;
        period = 16'd0;
        en = 1'b1;
        n0 = ncnv;
        bz = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) bz++;
        end
        chk("m0_cnv", ncnv - n0, 0);
        chk("m0_busy", bz, 0);
        ch_mask = 4'b0001;
        rises = 0;
        pb = 0;
        repeat (400) begin
            @(negedge clk);
            if (busy && pb == 0) rises++;
            pb = int'(busy);
        end
        chk("b2b_scans", int'(rises >= 2), 1);
        chk("b2b_res", int'(obs_d.size() >= 2), 1);
        en = 1'b0;
        wait_busy(1'b0, 500, "b2b_end");
        pulse_clr();

        flush();
        wh_ch = 2;
        ch_mask = 4'b0100;
        period = 16'd5;
        en = 1'b1;
        n0 = ncnv;
        k = 0;
        while (ncnv == n0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rst_cnv_seen", int'(ncnv > n0), 1);
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_mux", int'(mux_sel), 2);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_mux", int'(mux_sel), 0);
        chk("arst_cnvst", int'(cnvst), 0);
        chk("arst_valid", int'(res_valid), 0);
        chk("arst_data", int'(res_data), 0);
        @(negedge clk);
        rst = 1'b0;
        wh_ch = -1;
        @(negedge clk);
        late_req++;
        bz = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || res_valid || cnvst) bz++;
        end
        chk("late_eoc", bz, 0);
        chk("late_to", int'(timeout_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
